// File: rtl/fir_pkg.sv
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared state encoding and constants for the FIR stream engine.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_WAIT_IN = 3'd2,
    ST_MAC     = 3'd3,
    ST_OUT     = 3'd4,
    ST_DONE    = 3'd5
  } fir_state_e;

  localparam int DEFAULT_TAP_NUM = 11;
  localparam int BYTE_STRIDE     = 4;

  // Word index to BRAM byte address.
  function automatic int byte_addr(input int word);
    return word * BYTE_STRIDE;
  endfunction

endpackage : fir_pkg

`default_nettype wire

// File: rtl/fir_mac.sv
// ============================================================================
// Module   : fir_mac
// Purpose  : Registered multiply-accumulate; acc updates one cycle after en.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_mac #(
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic [pDATA_WIDTH-1:0] a,
  input  logic [pDATA_WIDTH-1:0] b,
  output logic [pDATA_WIDTH-1:0] acc
);

  logic [pDATA_WIDTH-1:0] acc_q;
  logic [pDATA_WIDTH-1:0] acc_d;
  logic [pDATA_WIDTH-1:0] prod;

  // Only the low word of the product is kept; the sum wraps naturally.
  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule : fir_mac

`default_nettype wire

// File: rtl/fir_stream_engine.sv
// ============================================================================
// Module   : fir_stream_engine
// Purpose  : Streaming FIR engine, one tap per cycle against tap/data BRAMs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_stream_engine
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_NUM    = DEFAULT_TAP_NUM
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ap_start,
  input  logic [pDATA_WIDTH-1:0] xfer_len,
  output logic                   reset_ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  input  logic [pDATA_WIDTH-1:0] data_Do
);

  localparam int IDX_W = (pTAP_NUM > 1) ? $clog2(pTAP_NUM) : 1;
  localparam int K_W   = $clog2(pTAP_NUM + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(pTAP_NUM - 1);
  localparam logic [K_W-1:0]   K_END    = K_W'(pTAP_NUM);

  fir_state_e             state_q, state_d;
  logic [IDX_W-1:0]       head_q, head_d;
  logic [IDX_W-1:0]       clr_idx_q, clr_idx_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [pDATA_WIDTH-1:0] count_q, count_d;
  logic [pDATA_WIDTH-1:0] xfer_len_q, xfer_len_d;
  logic                   reset_ap_start_q, reset_ap_start_d;

  logic [pDATA_WIDTH-1:0] count_inc;
  logic [IDX_W-1:0]       rd_idx;
  logic [IDX_W:0]         head_ext;
  logic [IDX_W:0]         k_ext;
  logic                   mac_clr;
  logic                   mac_en;
  logic [pDATA_WIDTH-1:0] mac_acc;

  // Stream framing comes from xfer_len, so tlast is deliberately not consumed.
  logic unused_tlast;
  assign unused_tlast = ss_tlast;

  // History index (head - k) mod pTAP_NUM without a divider.
  always_comb begin
    head_ext = {1'b0, head_q};
    k_ext    = (IDX_W + 1)'(k_q);
    if (head_ext >= k_ext) begin
      rd_idx = IDX_W'(head_ext - k_ext);
    end else begin
      rd_idx = IDX_W'(head_ext + (IDX_W + 1)'(pTAP_NUM) - k_ext);
    end
  end

  assign count_inc = count_q + pDATA_WIDTH'(1);

  always_comb begin
    state_d          = state_q;
    head_d           = head_q;
    clr_idx_d        = clr_idx_q;
    k_d              = k_q;
    count_d          = count_q;
    xfer_len_d       = xfer_len_q;
    reset_ap_start_d = 1'b0;
    ap_idle          = 1'b0;
    ap_done          = 1'b0;
    ss_tready        = 1'b0;
    sm_tvalid        = 1'b0;
    sm_tlast         = 1'b0;
    tap_EN           = 1'b0;
    tap_A            = '0;
    data_EN          = 1'b0;
    data_WE          = 4'h0;
    data_A           = '0;
    data_Di          = '0;
    mac_clr          = 1'b0;
    mac_en           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          reset_ap_start_d = 1'b1;
          xfer_len_d       = xfer_len;
          head_d           = '0;
          count_d          = '0;
          clr_idx_d        = '0;
          state_d          = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = pADDR_WIDTH'(byte_addr(int'(clr_idx_q)));
        if (clr_idx_q == LAST_IDX) begin
          state_d = (xfer_len_q == '0) ? ST_DONE : ST_WAIT_IN;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end

      ST_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          data_A  = pADDR_WIDTH'(byte_addr(int'(head_q)));
          data_Di = ss_tdata;
          mac_clr = 1'b1;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end

      // Reads issue on k=0..N-1; each product lands one cycle later, so the
      // final cycle (k==N) only accumulates.
      ST_MAC: begin
        mac_en = (k_q != '0);
        if (k_q == K_END) begin
          state_d = ST_OUT;
        end else begin
          tap_EN  = 1'b1;
          tap_A   = pADDR_WIDTH'(byte_addr(int'(k_q)));
          data_EN = 1'b1;
          data_A  = pADDR_WIDTH'(byte_addr(int'(rd_idx)));
          k_d     = k_q + K_W'(1);
        end
      end

      ST_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = (count_inc == xfer_len_q);
        if (sm_tready) begin
          count_d = count_inc;
          if (count_inc == xfer_len_q) begin
            state_d = ST_DONE;
          end else begin
            head_d  = (head_q == LAST_IDX) ? '0 : head_q + IDX_W'(1);
            state_d = ST_WAIT_IN;
          end
        end
      end

      ST_DONE: begin
        ap_done = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      head_q           <= '0;
      clr_idx_q        <= '0;
      k_q              <= '0;
      count_q          <= '0;
      xfer_len_q       <= '0;
      reset_ap_start_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      head_q           <= head_d;
      clr_idx_q        <= clr_idx_d;
      k_q              <= k_d;
      count_q          <= count_d;
      xfer_len_q       <= xfer_len_d;
      reset_ap_start_q <= reset_ap_start_d;
    end
  end

  assign reset_ap_start = reset_ap_start_q;

  // The accumulator only moves during WAIT_IN/MAC, so it doubles as the
  // output holding register while OUT waits on sm_tready.
  fir_mac #(
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (tap_Do),
    .b     (data_Do),
    .acc   (mac_acc)
  );

  assign sm_tdata = mac_acc;

endmodule : fir_stream_engine

`default_nettype wire

// File: tb/tb_fir_stream_engine.sv
// ============================================================================
// Module   : tb_fir_stream_engine
// Purpose  : Randomized self-checking bench for fir_stream_engine.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_stream_engine;

  localparam int N  = 11;
  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic [DW-1:0] xfer_len = '0;
  logic          reset_ap_start, ap_done, ap_idle;
  logic          ss_tvalid = 1'b0;
  logic [DW-1:0] ss_tdata = '0;
  logic          ss_tlast = 1'b0;
  logic          ss_tready;
  logic          sm_tvalid, sm_tlast;
  logic [DW-1:0] sm_tdata;
  logic          sm_tready = 1'b0;
  logic          tap_EN, data_EN;
  logic [AW-1:0] tap_A, data_A;
  logic [DW-1:0] tap_Do, data_Do, data_Di;
  logic [3:0]    data_WE;

  always #5 clk = ~clk;

  fir_stream_engine #(
    .pADDR_WIDTH(AW),
    .pDATA_WIDTH(DW),
    .pTAP_NUM   (N)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ap_start      (ap_start),
    .xfer_len      (xfer_len),
    .reset_ap_start(reset_ap_start),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ss_tvalid     (ss_tvalid),
    .ss_tdata      (ss_tdata),
    .ss_tlast      (ss_tlast),
    .ss_tready     (ss_tready),
    .sm_tvalid     (sm_tvalid),
    .sm_tdata      (sm_tdata),
    .sm_tlast      (sm_tlast),
    .sm_tready     (sm_tready),
    .tap_EN        (tap_EN),
    .tap_A         (tap_A),
    .tap_Do        (tap_Do),
    .data_EN       (data_EN),
    .data_WE       (data_WE),
    .data_A        (data_A),
    .data_Di       (data_Di),
    .data_Do       (data_Do)
  );

  // BRAM models: address sampled at the edge, data valid the next cycle.
  logic [DW-1:0] tap_mem [N];
  logic [DW-1:0] data_mem[N];

  always @(posedge clk) begin : bram_model
    int ti, di;
    ti = int'(tap_A) / 4;
    di = int'(data_A) / 4;
    if (tap_EN) tap_Do <= (ti < N) ? tap_mem[ti] : 32'hDEAD_BEEF;
    if (data_EN) begin
      data_Do <= (di < N) ? data_mem[di] : 32'hDEAD_BEEF;
      if (data_WE == 4'hF && di < N) data_mem[di] <= data_Di;
    end
  end

  int rs_pulses = 0, done_pulses = 0, valid_cycles = 0;
  always @(posedge clk) begin
    if (reset_ap_start) rs_pulses++;
    if (ap_done) done_pulses++;
    if (sm_tvalid) valid_cycles++;
  end

  int n_checks = 0, n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: y[n] = sum_k taps[k]*x[n-k], zero history before the run, mod 2^32.
  logic [DW-1:0] taps[N];
  logic [DW-1:0] xs[$];
  logic [DW-1:0] got_q[$];

  function automatic logic [DW-1:0] ref_y(input int n);
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++)
      if (n - k >= 0) s += taps[k] * xs[n-k];
    return s;
  endfunction

  task automatic load_taps(input bit ramp);
    for (int k = 0; k < N; k++) begin
      taps[k]    = ramp ? DW'(k + 1) : DW'($urandom);
      tap_mem[k] = taps[k];
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, " ap_idle"}, ap_idle, 1);
    check_val({tag, " ap_done"}, ap_done, 0);
    check_val({tag, " reset_ap_start"}, reset_ap_start, 0);
    check_val({tag, " ss_tready"}, ss_tready, 0);
    check_val({tag, " sm_tvalid"}, sm_tvalid, 0);
    check_val({tag, " sm_tlast"}, sm_tlast, 0);
    check_val({tag, " sm_tdata"}, sm_tdata, 0);
    check_val({tag, " data_WE"}, data_WE, 0);
    check_val({tag, " tap_EN"}, tap_EN, 0);
  endtask

  task automatic start_run(input int len);
    @(negedge clk);
    xfer_len = DW'(len);
    ap_start = 1'b1;
    @(negedge clk);
    check_val("reset_ap_start pulse", reset_ap_start, 1);
    check_val("ap_idle after accept", ap_idle, 0);
    ap_start = 1'b0;
    xfer_len = DW'($urandom);
  endtask

  task automatic send_sample(input logic [DW-1:0] x, input bit last);
    int t;
    ss_tvalid = 1'b1;
    ss_tdata  = x;
    ss_tlast  = last;
    t = 0;
    while (!ss_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_val("ss_tready", ss_tready, 1);
    @(negedge clk);
    ss_tvalid = 1'b0;
    ss_tdata  = DW'($urandom);
    ss_tlast  = 1'b0;
  endtask

  task automatic run_stream(input int len, input int stall_first, input bit reassert);
    int rs0, d0, lat, stall;
    rs0 = rs_pulses;
    d0  = done_pulses;
    got_q.delete();
    start_run(len);
    for (int n = 0; n < len; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_sample(xs[n], n == len - 1);
      lat = 1;
      while (!sm_tvalid && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      check_val("latency", lat, N + 2);
      check_val($sformatf("y[%0d]", n), sm_tdata, ref_y(n));
      check_val("sm_tlast", sm_tlast, n == len - 1);
      got_q.push_back(sm_tdata);
      if (reassert && n == 0) ap_start = 1'b1;
      if (reassert && n == len - 1) ap_start = 1'b0;
      stall = (n == 0) ? stall_first : $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check_val("stall sm_tvalid", sm_tvalid, 1);
        check_val("stall sm_tdata", sm_tdata, ref_y(n));
        check_val("stall ss_tready", ss_tready, 0);
      end
      sm_tready = 1'b1;
      @(negedge clk);
      sm_tready = 1'b0;
      if (n < len - 1) check_val("ap_done early", ap_done, 0);
    end
    check_val("ap_done", ap_done, 1);
    @(negedge clk);
    check_val("ap_done width", ap_done, 0);
    check_val("ap_idle after done", ap_idle, 1);
    check_val("reset_ap_start count", rs_pulses - rs0, 1);
    check_val("ap_done count", done_pulses - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t, v0, d0;
    logic [DW-1:0] x;

    repeat (3) @(negedge clk);
    check_reset("in reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("after reset");

    // Ramp taps, x = 1,2,3.
    load_taps(1'b1);
    xs.delete();
    for (int i = 1; i <= 3; i++) xs.push_back(DW'(i));
    run_stream(3, 0, 1'b0);
    check_val("ramp y0", got_q[0], 1);
    check_val("ramp y1", got_q[1], 4);
    check_val("ramp y2", got_q[2], 10);

    // All ones over 13 samples exercises head wrap.
    xs.delete();
    for (int i = 0; i < 13; i++) xs.push_back(1);
    run_stream(13, 0, 1'b0);
    check_val("ones y10", got_q[10], 66);
    check_val("ones y12", got_q[12], 66);

    // Zero-length run.
    v0 = valid_cycles;
    d0 = done_pulses;
    start_run(0);
    t = 0;
    while (!ap_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_val("len0 ap_done", ap_done, 1);
    @(negedge clk);
    check_val("len0 ap_idle", ap_idle, 1);
    check_val("len0 ap_done count", done_pulses - d0, 1);
    check_val("len0 sm_tvalid cycles", valid_cycles - v0, 0);

    // Long backpressure on the first output.
    load_taps(1'b0);
    xs.delete();
    for (int i = 0; i < 5; i++) xs.push_back(DW'($urandom));
    run_stream(5, 20, 1'b0);

    // ap_start reasserted mid-run; repeated run must see cleared history.
    xs.delete();
    for (int i = 0; i < 4; i++) xs.push_back(DW'($urandom));
    run_stream(4, 0, 1'b1);
    run_stream(4, 0, 1'b0);

    // Asynchronous reset during MAC.
    start_run(3);
    x = DW'($urandom);
    send_sample(x, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("mid-MAC reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xs.delete();
    for (int i = 0; i < 3; i++) xs.push_back(DW'($urandom));
    run_stream(3, 0, 1'b0);

    // Random runs with full-width taps and samples.
    for (int r = 0; r < 4; r++) begin
      load_taps(1'b0);
      xs.delete();
      t = $urandom_range(1, 15);
      for (int i = 0; i < t; i++) xs.push_back(DW'($urandom));
      run_stream(t, $urandom_range(0, 4), 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fir_stream_engine

`default_nettype wire

// File: doc/fir_stream_engine.md
Name: fir_stream_engine

Overview:
- FIR compute engine directly downstream of the AXI-Lite control block.
- Consumes ap_start and the transfer length from that block; returns reset_ap_start, ap_done and ap_idle.
- Streams samples in on AXI-Stream ss_*, computes one output per input sample, and streams results out on sm_*.
- Uses one sequential MAC (one tap per cycle), reading coefficients from the tap BRAM and holding sample history in a circular data BRAM.

Parameters:
pADDR_WIDTH, 12, BRAM byte-address width
pDATA_WIDTH, 32, sample/coef/result width
pTAP_NUM, 11, number of taps; also the data BRAM depth in words

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ap_start  in  1  start level from control block
xfer_len  in  pDATA_WIDTH  number of samples per run
reset_ap_start  out  1  one-cycle pulse on run accept; clears ap_start
ap_done  out  1  one-cycle pulse when the last output is accepted
ap_idle  out  1  level: 1 when no run is active
ss_tvalid  in  1  input sample valid
ss_tdata  in  pDATA_WIDTH  input sample
ss_tlast  in  1  input last; ignored for control
ss_tready  out  1  input ready
sm_tvalid  out  1  output valid
sm_tdata  out  pDATA_WIDTH  output result
sm_tlast  out  1  asserted with the final output of a run
sm_tready  in  1  output ready
tap_EN  out  1  tap BRAM enable (engine read port)
tap_A  out  pADDR_WIDTH  tap byte address, 4*k
tap_Do  in  pDATA_WIDTH  tap read data
data_EN  out  1  data BRAM enable
data_WE  out  4  data BRAM byte write enables
data_A  out  pADDR_WIDTH  data byte address, 4*idx
data_Di  out  pDATA_WIDTH  data write data
data_Do  in  pDATA_WIDTH  data read data

Behaviour:
- Reset values:
  - state IDLE; ap_idle=1; ap_done=0; reset_ap_start=0.
  - ss_tready=0; sm_tvalid=0; sm_tlast=0; sm_tdata=0.
  - data_WE=0; head=0; count=0; acc=0.
- BRAM model: the address is sampled at a clock edge, and Do is valid in the following cycle (1-cycle read latency).
- Arithmetic:
  - Product is the low pDATA_WIDTH bits of tap*sample.
  - Accumulation wraps modulo 2^pDATA_WIDTH (two's-complement consistent).
- FSM states: IDLE, CLEAR, WAIT_IN, MAC, OUT, DONE.
- IDLE:
  - ap_idle=1.
  - If ap_start=1, pulse reset_ap_start for one cycle, drop ap_idle the next cycle, set head=0 and count=0, and go to CLEAR.
- CLEAR:
  - Writes 0 to data words 0..pTAP_NUM-1, one per cycle with data_WE=4'hF (pTAP_NUM cycles).
  - Then go to DONE if xfer_len==0, otherwise go to WAIT_IN.
- WAIT_IN:
  - ss_tready=1.
  - On ss_tvalid&ss_tready, write ss_tdata to data[head], clear acc, set k=0, and go to MAC.
  - ss_tready is 0 in every other state.
- MAC:
  - Issue tap[k] and data[(head-k) mod pTAP_NUM] reads for k=0..pTAP_NUM-1.
  - acc += tap_Do*data_Do one cycle after each issue.
  - Exits after pTAP_NUM+1 cycles, latching acc into sm_tdata, then go to OUT.
- OUT:
  - sm_tvalid=1; sm_tlast=(count==xfer_len-1).
  - sm_tdata is held stable until sm_tready.
  - On the handshake: count++.
  - If count+1==xfer_len, go to DONE; otherwise head=(head+1) mod pTAP_NUM (wraps pTAP_NUM-1 -> 0) and go to WAIT_IN.
- DONE: pulse ap_done for one cycle, then go to IDLE with ap_idle=1.
- Latency: one input handshake to sm_tvalid is pTAP_NUM+2 cycles.
- ap_start while not IDLE: ignored; no second reset_ap_start pulse.
- xfer_len is sampled at run accept; later changes do not affect the current run.
- Backpressure: an sm_tready stall holds OUT indefinitely; no input is accepted during the stall.
- Asserting rst_n mid-run returns immediately to reset values; the data BRAM contents are not guaranteed, and the next run's CLEAR restores zeros.
- tap_EN=1 only in MAC, so the top level muxes tap BRAM ownership to the control block whenever ap_idle=1.

Decomposition:
- Shared package fir_pkg:
  - FSM state encoding.
  - Default tap count.
  - Byte-address stride constant (4).
- Sub-module fir_mac: registered multiply-accumulate.
  - Inputs: clr, en, a, b.
  - Output: acc.
  - 1-cycle en-to-acc update.

Test Plan:
- Taps 1..11, xfer_len=3, x=1,2,3 -> sm_tdata=1,4,10; sm_tlast only on 10; ap_done one pulse after the third handshake.
- Taps 1..11, xfer_len=13, x all 1 -> outputs 1,3,6,...,66 then 66,66 (head wrap); final value 66.
- xfer_len=0 with ap_start=1 -> reset_ap_start pulse, CLEAR, ap_done pulse, no sm_tvalid, ap_idle returns to 1.
- Hold sm_tready=0 for 20 cycles on the first output -> sm_tdata stable, ss_tready=0 throughout, correct result on release.
- ap_start reasserted mid-run -> ignored; after DONE, a new run produces results identical to the first (history cleared).
- rst_n low during MAC -> all outputs return to reset values asynchronously; the next run is correct.
